// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the RockWave fetch stage.
//   NOP_INST : canonical no-op (addi x0, x0, 0) emitted on reset and on fetch timeout
//   PC_STEP  : sequential PC increment in bytes
//   if_state_e : fetch FSM states
package instruction_fetch_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam int unsigned PC_STEP  = 4;

   typedef enum logic {
      IfIdle,
      IfReq
   } if_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one instruction-memory read per phase_fetch strobe and
// registers the returned word with its PC and PC+4 for decode.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   phase_fetch              strobe starting a fetch (ignored while busy)
//   pc_update/jump_en/jump_addr  PC advance: jump target (word aligned) or PC+4
//   imem_req/imem_addr       read request and stable word-aligned address
//   imem_ack/imem_rdata      read response
//   inst/curr_pc_fd/next_pc_fd  registered fetch results for decode
//   fetch_done               one-cycle pulse when the decode outputs are updated
//   busy                     request outstanding
//   fetch_err/misalign_err   sticky timeout / misaligned-jump flags
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     TIMEOUT      = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            phase_fetch,
   input  logic            pc_update,
   input  logic            jump_en,
   input  logic [XLEN-1:0] jump_addr,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] curr_pc_fd,
   output logic [XLEN-1:0] next_pc_fd,
   output logic            fetch_done,
   output logic            busy,
   output logic            fetch_err,
   output logic            misalign_err
);

   localparam logic [XLEN-1:0] Step        = XLEN'(PC_STEP);
   // Counter holds the number of completed REQ cycles without ack; the last allowed one
   // is TIMEOUT-1, so the timeout fires on the TIMEOUT-th REQ cycle.
   localparam logic [7:0]      TimeoutLast = 8'(TIMEOUT - 1);

   if_state_e       state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [31:0]     inst_q, inst_d;
   logic [XLEN-1:0] curr_q, curr_d;
   logic [XLEN-1:0] next_q, next_d;
   logic            done_q, done_d;
   logic            ferr_q, ferr_d;
   logic            merr_q, merr_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      inst_d  = inst_q;
      curr_d  = curr_q;
      next_d  = next_q;
      done_d  = 1'b0;
      ferr_d  = ferr_q;
      pc_d    = pc_q;
      merr_d  = merr_q;

      unique case (state_q)
         IfIdle: begin
            if (phase_fetch) begin
               // Uses the pre-update PC even if pc_update arrives in the same cycle.
               addr_d  = pc_q;
               cnt_d   = '0;
               state_d = IfReq;
            end
         end
         IfReq: begin
            if (imem_ack) begin
               // Ack wins over a coincident timeout.
               inst_d  = imem_rdata;
               curr_d  = addr_q;
               next_d  = addr_q + Step;
               done_d  = 1'b1;
               state_d = IfIdle;
            end else if (cnt_q == TimeoutLast) begin
               inst_d  = NOP_INST;
               curr_d  = addr_q;
               next_d  = addr_q + Step;
               ferr_d  = 1'b1;
               done_d  = 1'b1;
               state_d = IfIdle;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IfIdle;
      endcase

      // PC updates are independent of the FSM; an in-flight fetch keeps addr_q.
      if (pc_update) begin
         if (jump_en) begin
            pc_d = {jump_addr[XLEN-1:2], 2'b00};
            if (jump_addr[1:0] != 2'b00) merr_d = 1'b1;
         end else begin
            pc_d = pc_q + Step;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IfIdle;
         cnt_q   <= '0;
         pc_q    <= RESET_VECTOR;
         addr_q  <= RESET_VECTOR;
         inst_q  <= NOP_INST;
         curr_q  <= RESET_VECTOR;
         next_q  <= RESET_VECTOR + Step;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         merr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         inst_q  <= inst_d;
         curr_q  <= curr_d;
         next_q  <= next_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         merr_q  <= merr_d;
      end
   end

   assign busy         = (state_q == IfReq);
   assign imem_req     = busy;
   assign imem_addr    = addr_q;
   assign inst         = inst_q;
   assign curr_pc_fd   = curr_q;
   assign next_pc_fd   = next_q;
   assign fetch_done   = done_q;
   assign fetch_err    = ferr_q;
   assign misalign_err = merr_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the multi-phase RockWave core, directly upstream of `instruction_decode`. Owns the program counter and issues one instruction-memory read per `phase_fetch` strobe over a req/ack handshake with variable latency. Registers the fetched word with its current and next PC for decode. Applies PC updates (sequential or jump) from the later stages.

## Interface
Parameters:
- `XLEN`, 32, data/address width (from `core_general.vh`).
- `RESET_VECTOR`, 32'h0000_0000, PC value after reset.
- `TIMEOUT`, 255, maximum wait cycles for `imem_ack` (range 1..255).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  core clock.
  - `rst`  in  1  asynchronous, active-high reset.
- Control:
  - `phase_fetch`  in  1  single-cycle strobe that starts a fetch.
  - `pc_update`  in  1  single-cycle strobe that advances the PC.
  - `jump_en`  in  1  qualifies `pc_update`: 1 = take `jump_addr`, 0 = PC+4.
  - `jump_addr`  in  XLEN  jump target.
- Instruction memory:
  - `imem_req`  out  1  read request.
  - `imem_addr`  out  XLEN  read address, word aligned.
  - `imem_ack`  in  1  read data valid this cycle.
  - `imem_rdata`  in  32  read data.
- To decode:
  - `inst`  out  32  fetched instruction.
  - `curr_pc_fd`  out  XLEN  PC of `inst`.
  - `next_pc_fd`  out  XLEN  `curr_pc_fd` + 4.
- Status:
  - `fetch_done`  out  1  one-cycle pulse when `inst` is updated.
  - `busy`  out  1  high in REQ.
  - `fetch_err`  out  1  sticky: timeout occurred.
  - `misalign_err`  out  1  sticky: jump target with `[1:0]` != 0.

## Operation
- State machine: IDLE, REQ. `busy` = (state == REQ).
- **IDLE:**
  - On `phase_fetch`: latch `imem_addr` <= `pc`, assert `imem_req`, clear the wait counter, go to REQ.
  - Otherwise hold.
- **REQ:**
  - `imem_req` stays high and `imem_addr` stays stable until ack or timeout.
  - On `imem_ack`:
    - `inst` <= `imem_rdata`.
    - `curr_pc_fd` <= `imem_addr`.
    - `next_pc_fd` <= `imem_addr` + 4 (modulo 2^XLEN; wrap from 0xFFFF_FFFC to 0).
    - Pulse `fetch_done`, drop `imem_req`, go to IDLE.
  - Otherwise the counter increments. When it reaches `TIMEOUT`:
    - `inst` <= NOP (32'h0000_0013), with `curr_pc_fd`/`next_pc_fd` loaded as on ack.
    - Set `fetch_err`, pulse `fetch_done`, go to IDLE.
  - `phase_fetch` is ignored while in REQ.
- **PC register:**
  - On `pc_update`: `pc` <= `jump_en` ? {`jump_addr`[XLEN-1:2], 2'b00} : `pc` + 4.
  - If `jump_en` and `jump_addr`[1:0] != 0, set `misalign_err`.
  - `pc_update` is legal in any state. An in-flight fetch keeps its latched `imem_addr`; the new PC is used by the next fetch.
- **Simultaneous events:**
  - `phase_fetch` and `pc_update` in the same IDLE cycle: the fetch uses the old `pc`.
  - `imem_ack` in the same cycle the counter hits `TIMEOUT`: the ack wins and `fetch_err` is not set.
- Sticky flags clear only on `rst`.

## Timing
- Reset values:
  - `pc` = `RESET_VECTOR`.
  - `imem_addr` = `RESET_VECTOR`; `imem_req` = 0.
  - `inst` = 32'h0000_0013.
  - `curr_pc_fd` = `RESET_VECTOR`; `next_pc_fd` = `RESET_VECTOR` + 4.
  - `fetch_done`, `busy`, `fetch_err`, `misalign_err` = 0; state = IDLE.
- Reset mid-fetch: `imem_req` drops asynchronously; any late `imem_ack` after reset release is ignored in IDLE.
- `imem_req` rises the cycle after `phase_fetch`.
- Minimum latency, `phase_fetch` to `fetch_done`: 2 cycles (ack in the first REQ cycle).
- `inst`/PC outputs change only on the `fetch_done` edge and are held stable until the next `fetch_done`.
- Timeout fires on the `TIMEOUT`-th REQ cycle without ack.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Add to `core_general.vh`: `NOP_INST` = 32'h0000_0013, `IF_IDLE`/`IF_REQ` state encodings, `PC_STEP` = 4.
- No sub-module: the PC adder, counter and FSM stay inline.
- Output registers use an async active-high reset, so `obuf` is not reused.

## Test plan
- **Reset then fetch:** reset release, `phase_fetch`, ack in 1st REQ cycle with rdata 0x00500093 -> `imem_addr` = 0; `inst` = 0x00500093, `curr_pc_fd` = 0, `next_pc_fd` = 4, `fetch_done` 2 cycles after strobe.
- **Sequential PC:** `pc_update` with `jump_en` = 0, then fetch with ack after 5 cycles -> `imem_addr` = 4, `imem_req` held 5 cycles, `curr_pc_fd` = 4, `next_pc_fd` = 8.
- **Jump during fetch:** `pc_update`+`jump_en`, `jump_addr` = 0x100, issued while REQ at 0x8 -> that fetch completes at 0x8; next fetch is at 0x100. `jump_addr` = 0x102 -> `misalign_err` = 1, PC = 0x100.
- **Timeout:** `TIMEOUT` = 4, no ack -> `fetch_done` after 4 REQ cycles, `inst` = 0x00000013, `fetch_err` stays 1. Ack arriving on cycle 4 instead -> data taken, `fetch_err` = 0.
- **Wrap-around:** PC = 0xFFFF_FFFC, fetch -> `next_pc_fd` = 0; `pc_update` -> PC = 0.
- **Reset mid-fetch:** assert `rst` in REQ -> `imem_req` = 0 immediately, all outputs at reset values; a stray ack afterwards produces no `fetch_done`.
